// File: rtl/bp_be_regfile_wb_arbiter_pkg.sv
// bp_be_regfile_wb_arbiter_pkg: shared types for the regfile writeback arbiter
package bp_be_regfile_wb_arbiter_pkg;

    localparam int wb_data_width_lp = 64;
    localparam int wb_addr_width_lp = 5;

    typedef struct packed {
        logic [wb_addr_width_lp-1:0] addr;
        logic [wb_data_width_lp-1:0] data;
    } bp_be_wb_req_s;

    typedef enum logic {
        e_late_long = 1'b0,
        e_late_mem  = 1'b1
    } bp_be_late_src_e;

endpackage

// File: rtl/bp_be_wb_late_fifo.sv
// bp_be_wb_late_fifo: per-source late writeback buffer with head starvation counter
module bp_be_wb_late_fifo
    import bp_be_regfile_wb_arbiter_pkg::*;
#(
    parameter int data_width_p     = wb_data_width_lp,
    parameter int reg_addr_width_p = wb_addr_width_lp,
    parameter int els_p            = 2,
    parameter int starve_limit_p   = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        v_i,
    input  logic [reg_addr_width_p-1:0] addr_i,
    input  logic [data_width_p-1:0]     data_i,
    input  logic                        pop_i,
    output logic                        full_o,
    output logic                        head_v_o,
    output logic [reg_addr_width_p-1:0] head_addr_o,
    output logic [data_width_p-1:0]     head_data_o,
    output logic                        starve_o
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(starve_limit_p) + 1;
    localparam logic [cnt_w_lp-1:0] lim_lp = cnt_w_lp'(starve_limit_p - 1);

    logic [reg_addr_width_p-1:0] addr_mem [els_p];
    logic [data_width_p-1:0]     data_mem [els_p];
    logic [ptr_w_lp-1:0]         wptr_r, rptr_r;
    logic [ptr_w_lp:0]           count_r;
    logic [cnt_w_lp-1:0]         starve_r;
    logic                        push;

    assign full_o      = count_r == (ptr_w_lp+1)'(els_p);
    assign head_v_o    = count_r != '0;
    assign push        = v_i & ~full_o;
    assign head_addr_o = addr_mem[rptr_r];
    assign head_data_o = data_mem[rptr_r];
    assign starve_o    = head_v_o & (starve_r == lim_lp);

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wptr_r] <= addr_i;
            data_mem[wptr_r] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wptr_r   <= '0;
            rptr_r   <= '0;
            count_r  <= '0;
            starve_r <= '0;
        end else begin
            wptr_r   <= wptr_r + ptr_w_lp'(push);
            rptr_r   <= rptr_r + ptr_w_lp'(pop_i);
            count_r  <= count_r + (ptr_w_lp+1)'(push) - (ptr_w_lp+1)'(pop_i);
            starve_r <= (~head_v_o | pop_i) ? '0 : (starve_r == lim_lp) ? starve_r : starve_r + 1'b1;
        end
    end

endmodule

// File: rtl/bp_be_regfile_wb_arbiter.sv
// bp_be_regfile_wb_arbiter: packs pipe and buffered late writebacks onto two regfile write ports
module bp_be_regfile_wb_arbiter
    import bp_be_regfile_wb_arbiter_pkg::*;
#(
    parameter int data_width_p     = wb_data_width_lp,
    parameter int reg_addr_width_p = wb_addr_width_lp,
    parameter int late_fifo_els_p  = 2,
    parameter int starve_limit_p   = 4,
    parameter int zero_x0_p        = 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [1:0]                       pipe_v_i,
    input  logic [1:0][reg_addr_width_p-1:0] pipe_addr_i,
    input  logic [1:0][data_width_p-1:0]     pipe_data_i,
    input  logic [1:0]                       late_v_i,
    output logic [1:0]                       late_ready_and_o,
    input  logic [1:0][reg_addr_width_p-1:0] late_addr_i,
    input  logic [1:0][data_width_p-1:0]     late_data_i,
    output logic                             stall_o,
    output logic [1:0]                       rd_w_v_o,
    output logic [1:0][reg_addr_width_p-1:0] rd_addr_o,
    output logic [1:0][data_width_p-1:0]     rd_data_o,
    output logic                             conflict_o
);

    logic [1:0]                       full, head_v, starve, blocked, elig, gnt, rr_mask, sel_v;
    logic [1:0][reg_addr_width_p-1:0] head_addr, sel_addr;
    logic [1:0][data_width_p-1:0]     head_data, sel_data;
    logic [3:0]                       c_v;
    logic [3:0][reg_addr_width_p-1:0] c_addr;
    logic [3:0][data_width_p-1:0]     c_data;
    logic                             k0, k1, free2, free1, alive_r, rr;
    bp_be_late_src_e                  rr_r;

    assign late_ready_and_o = {2{alive_r}} & ~full;

    for (genvar s = 0; s < 2; s++) begin : g_late
        bp_be_wb_late_fifo #(
            .data_width_p     (data_width_p),
            .reg_addr_width_p (reg_addr_width_p),
            .els_p            (late_fifo_els_p),
            .starve_limit_p   (starve_limit_p)
        ) fifo (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .v_i         (late_v_i[s] & alive_r),
            .addr_i      (late_addr_i[s]),
            .data_i      (late_data_i[s]),
            .pop_i       (gnt[s]),
            .full_o      (full[s]),
            .head_v_o    (head_v[s]),
            .head_addr_o (head_addr[s]),
            .head_data_o (head_data[s]),
            .starve_o    (starve[s])
        );
        assign blocked[s] = head_v[s] & (head_addr[s] != '0)
                          & ((k0 & head_addr[s] == pipe_addr_i[0]) | (k1 & head_addr[s] == pipe_addr_i[1]));
    end

    // younger slot 1 overrides slot 0 on a same-register dual write
    assign k1      = pipe_v_i[1] & ~(zero_x0_p != 0 && pipe_addr_i[1] == '0);
    assign k0      = pipe_v_i[0] & ~(zero_x0_p != 0 && pipe_addr_i[0] == '0) & ~(k1 && pipe_addr_i[0] == pipe_addr_i[1]);
    assign free2   = ~k0 & ~k1;
    assign free1   = k0 ^ k1;
    assign rr      = rr_r;
    assign rr_mask = 2'b01 << rr;
    assign elig    = head_v & ~blocked;
    assign gnt     = free2 ? elig : free1 ? (((elig & rr_mask) != '0) ? rr_mask : (elig & ~rr_mask)) : 2'b00;

    assign c_v    = {gnt[~rr], gnt[rr], k1, k0};
    assign c_addr = {head_addr[~rr], head_addr[rr], pipe_addr_i[1], pipe_addr_i[0]};
    assign c_data = {head_data[~rr], head_data[rr], pipe_data_i[1], pipe_data_i[0]};

    always_comb begin
        sel_v    = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (c_v[i] && !sel_v[0]) begin
                sel_v[0]    = 1'b1;
                sel_addr[0] = c_addr[i];
                sel_data[0] = c_data[i];
            end else if (c_v[i]) begin
                sel_v[1]    = 1'b1;
                sel_addr[1] = c_addr[i];
                sel_data[1] = c_data[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            alive_r    <= 1'b0;
            rr_r       <= e_late_long;
            stall_o    <= 1'b0;
            conflict_o <= 1'b0;
            rd_w_v_o   <= '0;
            rd_addr_o  <= '0;
            rd_data_o  <= '0;
        end else begin
            alive_r    <= 1'b1;
            rr_r       <= (^gnt) ? bp_be_late_src_e'(~rr_r) : rr_r;
            stall_o    <= |(starve & ~gnt);
            conflict_o <= conflict_o | (|blocked) | (stall_o & (|pipe_v_i));
            rd_w_v_o   <= sel_v;
            for (int p = 0; p < 2; p++) begin
                if (sel_v[p]) begin
                    rd_addr_o[p] <= sel_addr[p];
                    rd_data_o[p] <= sel_data[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_bp_be_regfile_wb_arbiter.sv
// tb_bp_be_regfile_wb_arbiter: directed self-checking bench for the regfile writeback arbiter
module tb_bp_be_regfile_wb_arbiter;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [1:0]       pipe_v_i;
    logic [1:0][4:0]  pipe_addr_i;
    logic [1:0][63:0] pipe_data_i;
    logic [1:0]       late_v_i;
    logic [1:0]       late_ready_and_o;
    logic [1:0][4:0]  late_addr_i;
    logic [1:0][63:0] late_data_i;
    logic             stall_o;
    logic [1:0]       rd_w_v_o;
    logic [1:0][4:0]  rd_addr_o;
    logic [1:0][63:0] rd_data_o;
    logic             conflict_o;

    int checks = 0;
    int errors = 0;

    bp_be_regfile_wb_arbiter dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .pipe_v_i         (pipe_v_i),
        .pipe_addr_i      (pipe_addr_i),
        .pipe_data_i      (pipe_data_i),
        .late_v_i         (late_v_i),
        .late_ready_and_o (late_ready_and_o),
        .late_addr_i      (late_addr_i),
        .late_data_i      (late_data_i),
        .stall_o          (stall_o),
        .rd_w_v_o         (rd_w_v_o),
        .rd_addr_o        (rd_addr_o),
        .rd_data_o        (rd_data_o),
        .conflict_o       (conflict_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle;
        pipe_v_i    = '0;
        pipe_addr_i = '0;
        pipe_data_i = '0;
        late_v_i    = '0;
        late_addr_i = '0;
        late_data_i = '0;
    endtask

    task automatic do_reset;
        idle();
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        tick();
    endtask

    task automatic pipe2(input logic [4:0] a0, input logic [63:0] d0, input logic [4:0] a1, input logic [63:0] d1);
        pipe_v_i    = 2'b11;
        pipe_addr_i = {a1, a0};
        pipe_data_i = {d1, d0};
    endtask

    task automatic test_reset;
        idle();
        reset_i = 1'b0;
        tick();
        tick();
        checks++;
        if (rd_w_v_o !== 2'b00 || rd_addr_o !== '0 || rd_data_o !== '0 || stall_o !== 1'b0
            || conflict_o !== 1'b0 || late_ready_and_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: v=%b addr=%h data=%h stall=%b conflict=%b ready=%b, expected all zero",
                     rd_w_v_o, rd_addr_o, rd_data_o, stall_o, conflict_o, late_ready_and_o);
        end
        reset_i = 1'b1;
        tick();
        checks++;
        if (late_ready_and_o !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready_rise: ready=%b, expected 11", late_ready_and_o);
        end
        pipe2(5'd1, 64'h11, 5'd2, 64'h22);
        late_v_i    = 2'b11;
        late_addr_i = {5'd8, 5'd7};
        late_data_i = {64'h88, 64'h77};
        tick();
        late_v_i = 2'b00;
        reset_i  = 1'b0;
        #1;
        checks++;
        if (rd_w_v_o !== 2'b00 || late_ready_and_o !== 2'b00 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: v=%b ready=%b stall=%b, expected 00 00 0", rd_w_v_o, late_ready_and_o, stall_o);
        end
        idle();
        tick();
        reset_i = 1'b1;
        #1;
        checks++;
        if (late_ready_and_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready_before_edge: ready=%b, expected 00", late_ready_and_o);
        end
        tick();
        checks++;
        if (late_ready_and_o !== 2'b11 || rd_w_v_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: ready=%b v=%b, expected 11 00", late_ready_and_o, rd_w_v_o);
        end
        tick();
        checks++;
        if (rd_w_v_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_queue_empty: v=%b, expected 00", rd_w_v_o);
        end
    endtask

    task automatic test_pipe_priority;
        do_reset();
        pipe2(5'd1, 64'h11, 5'd2, 64'h22);
        late_v_i       = 2'b01;
        late_addr_i[0] = 5'd7;
        late_data_i[0] = 64'hC;
        tick();
        late_v_i = 2'b00;
        pipe2(5'd3, 64'hA, 5'd4, 64'hB);
        tick();
        checks++;
        if (rd_w_v_o !== 2'b11 || rd_addr_o[0] !== 5'd3 || rd_addr_o[1] !== 5'd4
            || rd_data_o[0] !== 64'hA || rd_data_o[1] !== 64'hB) begin
            errors++;
            $display("FAIL pipe_priority: v=%b a0=%0d d0=%h a1=%0d d1=%h, expected 11 3 a 4 b",
                     rd_w_v_o, rd_addr_o[0], rd_data_o[0], rd_addr_o[1], rd_data_o[1]);
        end
        idle();
        tick();
        checks++;
        if (rd_w_v_o !== 2'b01 || rd_addr_o[0] !== 5'd7 || rd_data_o[0] !== 64'hC
            || rd_addr_o[1] !== 5'd4 || rd_data_o[1] !== 64'hB || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL late_held_drain: v=%b a0=%0d d0=%h a1=%0d d1=%h stall=%b, expected 01 7 c 4 b 0",
                     rd_w_v_o, rd_addr_o[0], rd_data_o[0], rd_addr_o[1], rd_data_o[1], stall_o);
        end
    endtask

    task automatic test_same_addr;
        do_reset();
        pipe2(5'd5, 64'h1, 5'd5, 64'h2);
        tick();
        checks++;
        if (rd_w_v_o !== 2'b01 || rd_addr_o[0] !== 5'd5 || rd_data_o[0] !== 64'h2 || conflict_o !== 1'b0) begin
            errors++;
            $display("FAIL same_addr: v=%b a0=%0d d0=%h conflict=%b, expected 01 5 2 0",
                     rd_w_v_o, rd_addr_o[0], rd_data_o[0], conflict_o);
        end
        idle();
        tick();
    endtask

    task automatic test_starve(input logic keep_pipe);
        int seen;
        do_reset();
        pipe2(5'd1, 64'h11, 5'd2, 64'h22);
        late_v_i       = 2'b10;
        late_addr_i[1] = 5'd9;
        late_data_i[1] = 64'h99;
        tick();
        late_v_i = 2'b00;
        seen = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (stall_o) begin
                seen = i;
                break;
            end
        end
        checks++;
        if (seen != 4) begin
            errors++;
            $display("FAIL starve_stall_cycle: stall seen at cycle %0d, expected 4", seen);
        end
        if (!keep_pipe) begin
            pipe_v_i = 2'b00;
            tick();
            checks++;
            if (rd_w_v_o !== 2'b01 || rd_addr_o[0] !== 5'd9 || rd_data_o[0] !== 64'h99
                || stall_o !== 1'b0 || conflict_o !== 1'b0) begin
                errors++;
                $display("FAIL starve_drain: v=%b a0=%0d d0=%h stall=%b conflict=%b, expected 01 9 99 0 0",
                         rd_w_v_o, rd_addr_o[0], rd_data_o[0], stall_o, conflict_o);
            end
        end else begin
            tick();
            checks++;
            if (rd_w_v_o !== 2'b11 || rd_addr_o[0] !== 5'd1 || rd_addr_o[1] !== 5'd2 || conflict_o !== 1'b1) begin
                errors++;
                $display("FAIL stall_violation: v=%b a0=%0d a1=%0d conflict=%b, expected 11 1 2 1",
                         rd_w_v_o, rd_addr_o[0], rd_addr_o[1], conflict_o);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_full_x0_drain;
        do_reset();
        pipe2(5'd1, 64'h11, 5'd2, 64'h22);
        late_v_i    = 2'b11;
        late_addr_i = {5'd20, 5'd10};
        late_data_i = {64'hB0, 64'hA0};
        tick();
        late_addr_i = {5'd21, 5'd11};
        late_data_i = {64'hB1, 64'hA1};
        tick();
        checks++;
        if (late_ready_and_o !== 2'b00) begin
            errors++;
            $display("FAIL fifo_full_ready: ready=%b, expected 00", late_ready_and_o);
        end
        late_v_i       = 2'b00;
        pipe_v_i       = 2'b01;
        pipe_addr_i[0] = 5'd0;
        pipe_data_i[0] = 64'hDEAD;
        tick();
        checks++;
        if (rd_w_v_o !== 2'b11 || rd_addr_o[0] !== 5'd10 || rd_data_o[0] !== 64'hA0
            || rd_addr_o[1] !== 5'd20 || rd_data_o[1] !== 64'hB0 || late_ready_and_o !== 2'b11) begin
            errors++;
            $display("FAIL x0_drop_both_drain: v=%b a0=%0d d0=%h a1=%0d d1=%h ready=%b, expected 11 10 a0 20 b0 11",
                     rd_w_v_o, rd_addr_o[0], rd_data_o[0], rd_addr_o[1], rd_data_o[1], late_ready_and_o);
        end
        idle();
        tick();
        checks++;
        if (rd_w_v_o !== 2'b11 || rd_addr_o[0] !== 5'd11 || rd_addr_o[1] !== 5'd21) begin
            errors++;
            $display("FAIL second_drain: v=%b a0=%0d a1=%0d, expected 11 11 21", rd_w_v_o, rd_addr_o[0], rd_addr_o[1]);
        end
    endtask

    task automatic test_round_robin;
        do_reset();
        pipe2(5'd1, 64'h11, 5'd2, 64'h22);
        late_v_i    = 2'b11;
        late_addr_i = {5'd13, 5'd12};
        late_data_i = {64'hD0, 64'hC0};
        tick();
        late_v_i       = 2'b00;
        pipe_v_i       = 2'b01;
        pipe_addr_i[0] = 5'd14;
        pipe_data_i[0] = 64'hE;
        tick();
        checks++;
        if (rd_w_v_o !== 2'b11 || rd_addr_o[0] !== 5'd14 || rd_addr_o[1] !== 5'd12 || rd_data_o[1] !== 64'hC0) begin
            errors++;
            $display("FAIL rr_first: v=%b a0=%0d a1=%0d d1=%h, expected 11 14 12 c0",
                     rd_w_v_o, rd_addr_o[0], rd_addr_o[1], rd_data_o[1]);
        end
        pipe_addr_i[0] = 5'd15;
        tick();
        checks++;
        if (rd_w_v_o !== 2'b11 || rd_addr_o[0] !== 5'd15 || rd_addr_o[1] !== 5'd13 || rd_data_o[1] !== 64'hD0) begin
            errors++;
            $display("FAIL rr_second: v=%b a0=%0d a1=%0d d1=%h, expected 11 15 13 d0",
                     rd_w_v_o, rd_addr_o[0], rd_addr_o[1], rd_data_o[1]);
        end
        idle();
        tick();
    endtask

    task automatic test_conflict;
        do_reset();
        pipe2(5'd1, 64'h11, 5'd2, 64'h22);
        late_v_i       = 2'b01;
        late_addr_i[0] = 5'd6;
        late_data_i[0] = 64'h66;
        tick();
        late_v_i       = 2'b00;
        pipe_v_i       = 2'b01;
        pipe_addr_i[0] = 5'd6;
        pipe_data_i[0] = 64'h600;
        tick();
        checks++;
        if (rd_w_v_o !== 2'b01 || rd_addr_o[0] !== 5'd6 || rd_data_o[0] !== 64'h600 || conflict_o !== 1'b1) begin
            errors++;
            $display("FAIL conflict_pipe_wins: v=%b a0=%0d d0=%h conflict=%b, expected 01 6 600 1",
                     rd_w_v_o, rd_addr_o[0], rd_data_o[0], conflict_o);
        end
        idle();
        tick();
        checks++;
        if (rd_w_v_o !== 2'b01 || rd_addr_o[0] !== 5'd6 || rd_data_o[0] !== 64'h66 || conflict_o !== 1'b1) begin
            errors++;
            $display("FAIL conflict_deferred: v=%b a0=%0d d0=%h conflict=%b, expected 01 6 66 1",
                     rd_w_v_o, rd_addr_o[0], rd_data_o[0], conflict_o);
        end
        tick();
        checks++;
        if (rd_w_v_o !== 2'b00 || conflict_o !== 1'b1) begin
            errors++;
            $display("FAIL conflict_sticky: v=%b conflict=%b, expected 00 1", rd_w_v_o, conflict_o);
        end
        reset_i = 1'b0;
        #1;
        checks++;
        if (conflict_o !== 1'b0) begin
            errors++;
            $display("FAIL conflict_reset: conflict=%b, expected 0", conflict_o);
        end
        tick();
        reset_i = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_pipe_priority();
        test_same_addr();
        test_starve(1'b0);
        test_starve(1'b1);
        test_full_x0_drain();
        test_round_robin();
        test_conflict();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
